rand_bounded: RTL and testbench

//  Downstream consumer of the 32-bit free-running LFSR state.

---
 rtl/rand_pkg.sv | 10 +
 rtl/rand_mask_gen.sv | 20 ++
 rtl/rand_bounded.sv | 94 +++++++++
 tb/tb_rand_bounded.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and constants for the bounded random-number consumer.
package rand_pkg;
  localparam int LFSR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/rand_mask_gen.sv
// Smallest 2^k-1 covering bound-1 (bit-smear); bound 0 and 1 both give 0.
// Combinational, no backpressure.
module rand_mask_gen #(
  parameter int W = 8
) (
  input  logic [W-1:0] bound_i,
  output logic [W-1:0] mask_o
);
  logic [W-1:0] smear;

  always_comb begin
    smear = bound_i - W'(1);
    // Bound 0 would wrap to all-ones; it must collapse to a zero mask.
    if (bound_i == '0) smear = '0;
    for (int i = 1; i < W; i = i * 2) begin
      smear = smear | (smear >> i);
    end
    mask_o = smear;
  end
endmodule

// File: rtl/rand_bounded.sv
// Uniform integers in [0, bound) from LFSR state by masked rejection sampling.
// Result 2..MAX_TRY+1 cycles after request; held until rnd_ready_i, one request in flight.
module rand_bounded
  import rand_pkg::*;
#(
  parameter int W       = 8,
  parameter int TAP_OFS = 0,
  parameter int MAX_TRY = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [LFSR_W-1:0] lfsr_state_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [W-1:0]      bound_i,
  output logic              rnd_valid_o,
  input  logic              rnd_ready_i,
  output logic [W-1:0]      rnd_data_o
);
  localparam int TW = $clog2(MAX_TRY) + 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRY - 1);

  state_e        state_q;
  logic [TW-1:0] try_q;
  logic [W-1:0]  bound_q;
  logic [W-1:0]  mask_q;
  logic [W-1:0]  data_q;
  logic          valid_q;

  logic [W-1:0]  mask_d;
  logic [W-1:0]  sample;
  logic          accept;
  logic          unused_lfsr;

  rand_mask_gen #(.W(W)) u_mask (
    .bound_i (bound_i),
    .mask_o  (mask_d)
  );

  assign sample = lfsr_state_i[TAP_OFS +: W] & mask_q;
  // Bound 0 always yields 0 on the first draw, never via the fallback.
  assign accept = (sample < bound_q) || (bound_q == '0);
  assign unused_lfsr = ^lfsr_state_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      try_q   <= '0;
      bound_q <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            bound_q <= bound_i;
            mask_q  <= mask_d;
            try_q   <= '0;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (accept) begin
            data_q  <= sample;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (try_q == LAST_TRY) begin
            // sample <= mask < 2*bound, so one subtraction lands in range.
            data_q  <= sample - bound_q;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            try_q <= try_q + TW'(1);
          end
        end
        HOLD: begin
          if (rnd_ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign rnd_valid_o = valid_q;
  assign rnd_data_o  = data_q;
endmodule

// File: tb/tb_rand_bounded.sv
// Directed bench for rand_bounded with W=8, TAP_OFS=0, MAX_TRY=4.
module tb_rand_bounded;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] lfsr_state_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  bound_i;
  logic        rnd_valid_o;
  logic        rnd_ready_i;
  logic [7:0]  rnd_data_o;

  int checks   = 0;
  int failures = 0;

  rand_bounded #(.W(8), .TAP_OFS(0), .MAX_TRY(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lfsr_state_i (lfsr_state_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .bound_i      (bound_i),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_ready_i  (rnd_ready_i),
    .rnd_data_o   (rnd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake edge is cycle 0; returns in cycle 1 with the request dropped.
  task automatic request(input logic [7:0] b);
    req_valid_i = 1'b1;
    bound_i     = b;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic consume();
    rnd_ready_i = 1'b1;
    tick();
    rnd_ready_i = 1'b0;
  endtask

  initial begin
    reset_i      = 1'b1;
    lfsr_state_i = 32'h1234_5600;
    req_valid_i  = 1'b0;
    bound_i      = '0;
    rnd_ready_i  = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("rst_data", {24'd0, rnd_data_o}, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    chk("post_rst_req_ready", {31'd0, req_ready_o}, 32'd1);

    // Immediate accept: 0x27 & 0x0F = 7
    request(8'd10);
    chk("acc_c1_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("acc_c1_valid", {31'd0, rnd_valid_o}, 32'd0);
    lfsr_state_i = 32'hABCD_EF27;
    tick();
    chk("acc_c2_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("acc_c2_data", {24'd0, rnd_data_o}, 32'd7);
    consume();
    chk("acc_done_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("acc_done_req_ready", {31'd0, req_ready_o}, 32'd1);

    // Rejections: 12, 14 rejected, 3 accepted in cycle 3
    request(8'd10);
    lfsr_state_i = 32'h0000_000C;
    tick();
    chk("rej_c2_valid", {31'd0, rnd_valid_o}, 32'd0);
    lfsr_state_i = 32'h0000_000E;
    tick();
    chk("rej_c3_valid", {31'd0, rnd_valid_o}, 32'd0);
    lfsr_state_i = 32'hFFFF_FF03;
    tick();
    chk("rej_c4_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("rej_c4_data", {24'd0, rnd_data_o}, 32'd3);
    consume();

    // Fallback: 15 rejected four times -> 15-10 = 5 in cycle 5
    request(8'd10);
    lfsr_state_i = 32'h0000_00FF;
    tick();
    tick();
    tick();
    chk("fb_c4_valid", {31'd0, rnd_valid_o}, 32'd0);
    tick();
    chk("fb_c5_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("fb_c5_data", {24'd0, rnd_data_o}, 32'd5);
    consume();

    // bound 0 and bound 1 both give 0 after one draw
    request(8'd0);
    lfsr_state_i = 32'h0000_005A;
    tick();
    chk("b0_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("b0_data", {24'd0, rnd_data_o}, 32'd0);
    consume();
    request(8'd1);
    lfsr_state_i = 32'h0000_00FF;
    tick();
    chk("b1_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("b1_data", {24'd0, rnd_data_o}, 32'd0);
    consume();

    // Backpressure: 0x09 & 0x0F = 9, held while a bound=3 request is ignored
    request(8'd10);
    lfsr_state_i = 32'h0000_0009;
    tick();
    chk("bp_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("bp_data", {24'd0, rnd_data_o}, 32'd9);
    req_valid_i = 1'b1;
    bound_i     = 8'd3;
    for (int i = 0; i < 5; i++) begin
      lfsr_state_i = 32'h0000_0001 + 32'(i);
      tick();
      chk("bp_hold_valid", {31'd0, rnd_valid_o}, 32'd1);
      chk("bp_hold_data", {24'd0, rnd_data_o}, 32'd9);
      chk("bp_hold_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_valid_i = 1'b0;
    consume();
    chk("bp_done_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("bp_done_req_ready", {31'd0, req_ready_o}, 32'd1);

    // Reset in cycle 2 of the rejection scenario drops the result
    request(8'd10);
    lfsr_state_i = 32'h0000_000C;
    tick();
    reset_i = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("mid_rst_data", {24'd0, rnd_data_o}, 32'd0);
    lfsr_state_i = 32'h0000_0003;
    tick();
    reset_i = 1'b0;
    tick();
    chk("after_rst_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("after_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    request(8'd10);
    lfsr_state_i = 32'h0000_0004;
    tick();
    chk("after_rst_res_valid", {31'd0, rnd_valid_o}, 32'd1);
    chk("after_rst_res_data", {24'd0, rnd_data_o}, 32'd4);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
